// File: rtl/uart_tx_frame.sv
// UART transmit frame engine: start bit, DATA_WIDTH data bits LSB-first,
// optional parity bit, one or two stop bits; one bit per CLK (baud) cycle.
module uart_tx_frame #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  Data_Valid,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic                  STOP2,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int unsigned    CW       = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_en_q;
  logic                  par_bit_q;
  logic                  stop2_q;
  logic                  stop_second;

  // Outputs are registered alongside the state, so TX_OUT/Busy always show
  // the slot the FSM has just entered. The latched word is shifted right one
  // place per data bit, so shreg[0] is always data bit[cnt].
  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      cnt    <= '0;
      TX_OUT <= IDLE_LEVEL;
      Busy   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
          cnt    <= '0;
          if (Data_Valid) begin
            shreg     <= P_DATA;
            par_en_q  <= PAR_EN;
            par_bit_q <= (^P_DATA) ^ PAR_TYP;
            stop2_q   <= STOP2;
            state     <= START;
            TX_OUT    <= ~IDLE_LEVEL;
            Busy      <= 1'b1;
          end
        end

        START: begin
          state  <= DATA;
          cnt    <= '0;
          TX_OUT <= shreg[0];
        end

        DATA: begin
          if (cnt == CNT_LAST) begin
            stop_second <= 1'b0;
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= par_bit_q;
            end else begin
              state  <= STOP;
              TX_OUT <= IDLE_LEVEL;
            end
          end else begin
            cnt    <= cnt + CW'(1);
            shreg  <= shreg >> 1;
            TX_OUT <= shreg[1];
          end
        end

        PARITY: begin
          state       <= STOP;
          stop_second <= 1'b0;
          TX_OUT      <= IDLE_LEVEL;
        end

        STOP: begin
          TX_OUT <= IDLE_LEVEL;
          if (stop2_q && !stop_second) begin
            stop_second <= 1'b1;
          end else begin
            state <= IDLE;
            Busy  <= 1'b0;
          end
        end

        default: begin
          state  <= IDLE;
          cnt    <= '0;
          TX_OUT <= IDLE_LEVEL;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame at DATA_WIDTH 8, 5 and 16: stimulus pushes
// model frames, a negedge monitor rebuilds line frames from Busy/TX_OUT.
module tb_uart_tx_frame;

  typedef struct {
    logic [31:0] bits;
    int unsigned len;
  } frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pd = '0;
  logic [2:0]  dv = '0;
  logic        par_en = 1'b0;
  logic        par_typ = 1'b0;
  logic        stop2 = 1'b0;
  logic [2:0]  tx_w;
  logic [2:0]  busy_w;

  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  frame_t q0[$];
  frame_t q1[$];
  frame_t q2[$];

  bit          active [3];
  int unsigned pos    [3];
  logic [31:0] act    [3];

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_WIDTH(8)) dut8 (
    .CLK(clk), .RST(rst), .P_DATA(pd[7:0]), .Data_Valid(dv[0]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[0]), .Busy(busy_w[0])
  );

  uart_tx_frame #(.DATA_WIDTH(5)) dut5 (
    .CLK(clk), .RST(rst), .P_DATA(pd[4:0]), .Data_Valid(dv[1]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[1]), .Busy(busy_w[1])
  );

  uart_tx_frame #(.DATA_WIDTH(16)) dut16 (
    .CLK(clk), .RST(rst), .P_DATA(pd), .Data_Valid(dv[2]),
    .PAR_EN(par_en), .PAR_TYP(par_typ), .STOP2(stop2),
    .TX_OUT(tx_w[2]), .Busy(busy_w[2])
  );

  function automatic int unsigned width_of(input int i);
    return (i == 0) ? 8 : (i == 1) ? 5 : 16;
  endfunction

  // Reference frame: list of line levels, one per Busy cycle.
  function automatic frame_t model(input int unsigned w, input logic [15:0] d,
                                   input logic pe, input logic pt, input logic s2);
    frame_t      f;
    int unsigned n = 0;
    int unsigned ones = 0;
    f.bits = '0;
    f.bits[n] = 1'b0; n++;
    for (int unsigned b = 0; b < w; b++) begin
      f.bits[n] = d[b];
      ones += d[b];
      n++;
    end
    if (pe) begin
      f.bits[n] = ((ones % 2) == 1) ^ pt;
      n++;
    end
    f.bits[n] = 1'b1; n++;
    if (s2) begin
      f.bits[n] = 1'b1; n++;
    end
    f.len = n;
    return f;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic push_exp(input int i, input frame_t f);
    case (i)
      0: q0.push_back(f);
      1: q1.push_back(f);
      default: q2.push_back(f);
    endcase
  endtask

  task automatic pop_exp(input int i, output frame_t f, output bit ok);
    ok = 1'b0;
    f.bits = '0;
    f.len = 0;
    case (i)
      0: if (q0.size() > 0) begin f = q0.pop_front(); ok = 1'b1; end
      1: if (q1.size() > 0) begin f = q1.pop_front(); ok = 1'b1; end
      default: if (q2.size() > 0) begin f = q2.pop_front(); ok = 1'b1; end
    endcase
  endtask

  task automatic mon_step(input int i);
    frame_t      f;
    bit          ok;
    logic [31:0] mask;
    if (busy_w[i] === 1'b1) begin
      if (!active[i]) begin
        active[i] = 1'b1;
        pos[i] = 0;
        act[i] = '0;
      end
      if (pos[i] < 32) act[i][pos[i]] = tx_w[i];
      pos[i]++;
    end else begin
      if (active[i]) begin
        active[i] = 1'b0;
        pop_exp(i, f, ok);
        n_cmp++;
        if (!ok) begin
          n_err++;
          $display("FAIL unexpected_frame dut%0d: got frame of %0d cycles, required none", i, pos[i]);
        end else begin
          check($sformatf("frame_len dut%0d", i), pos[i], f.len);
          mask = (f.len >= 32) ? '1 : ((32'h1 << f.len) - 32'h1);
          check($sformatf("frame_bits dut%0d", i), act[i] & mask, f.bits & mask);
        end
      end
      check($sformatf("idle_line dut%0d", i), {31'b0, tx_w[i]}, 32'h1);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int i = 0; i < 3; i++) mon_step(i);
    end
  end

  // All stimulus runs at posedge+1.
  task automatic wait_idle(input int i);
    int t = 0;
    while (busy_w[i] !== 1'b0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 200) check($sformatf("wait_idle_timeout dut%0d", i), 32'h1, 32'h0);
  endtask

  // Requests a frame; returns one cycle after the accepting edge with dv still high.
  task automatic issue(input int i, input logic [15:0] d, input logic pe,
                       input logic pt, input logic s2, input frame_t f);
    wait_idle(i);
    pd = d; par_en = pe; par_typ = pt; stop2 = s2;
    dv[i] = 1'b1;
    push_exp(i, f);
    @(posedge clk); #1;
    check($sformatf("accept_busy dut%0d", i), {31'b0, busy_w[i]}, 32'h1);
    check($sformatf("accept_start dut%0d", i), {31'b0, tx_w[i]}, 32'h0);
  endtask

  // Random config/data/Data_Valid for the n Busy cycles of the frame in flight.
  task automatic scramble(input int i, input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      pd = 16'($urandom);
      par_en = 1'($urandom);
      par_typ = 1'($urandom);
      stop2 = 1'($urandom);
      dv[i] = 1'($urandom);
      @(posedge clk); #1;
    end
    dv[i] = 1'b0;
  endtask

  task automatic send(input int i, input logic [15:0] d, input logic pe,
                      input logic pt, input logic s2, input bit stir);
    frame_t f;
    f = model(width_of(i), d, pe, pt, s2);
    issue(i, d, pe, pt, s2, f);
    if (stir) scramble(i, f.len);
    else dv[i] = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 || active[0] || active[1] || active[2]) begin
      if (t >= 400) break;
      @(posedge clk); #1;
      t++;
    end
    check("drain_pending", q0.size() + q1.size() + q2.size(), 32'h0);
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    frame_t f;
    int     gap;
    int     t;

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("reset_tx dut%0d", i), {31'b0, tx_w[i]}, 32'h1);
      check($sformatf("reset_busy dut%0d", i), {31'b0, busy_w[i]}, 32'h0);
    end
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Directed frames from the test plan.
    send(0, 16'h00A5, 1'b1, 1'b0, 1'b0, 1'b0);
    send(0, 16'h0001, 1'b1, 1'b1, 1'b1, 1'b0);
    send(0, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0);
    send(1, 16'h001F, 1'b1, 1'b0, 1'b0, 1'b0);
    send(2, 16'h8001, 1'b0, 1'b0, 1'b0, 1'b0);
    send(2, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b0);
    drain();

    // Inputs and Data_Valid churned while Busy.
    send(0, 16'h003C, 1'b1, 1'b0, 1'b1, 1'b1);
    send(1, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b1);
    send(2, 16'hBEEF, 1'b1, 1'b0, 1'b1, 1'b1);
    drain();

    // Back-to-back with Data_Valid held: exactly one idle cycle between frames.
    f = model(8, 16'h0055, 1'b0, 1'b0, 1'b0);
    issue(0, 16'h0055, 1'b0, 1'b0, 1'b0, f);
    pd = 16'h00AA;
    push_exp(0, model(8, 16'h00AA, 1'b0, 1'b0, 1'b0));
    t = 0;
    while (busy_w[0] === 1'b1 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    gap = 0;
    while (busy_w[0] === 1'b0 && gap < 50) begin
      gap++;
      @(posedge clk); #1;
    end
    dv[0] = 1'b0;
    check("b2b_gap", gap, 32'd1);
    drain();

    // Reset during the 4th data bit aborts the frame at once.
    f = model(8, 16'h00A5, 1'b1, 1'b0, 1'b0);
    f.len = 5;
    issue(0, 16'h00A5, 1'b1, 1'b0, 1'b0, f);
    dv[0] = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_tx", {31'b0, tx_w[0]}, 32'h1);
    check("abort_busy", {31'b0, busy_w[0]}, 32'h0);
    rst = 1'b0;
    send(0, 16'h00C3, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Reset and Data_Valid on the same edge: nothing is latched.
    rst = 1'b1;
    dv[1] = 1'b1;
    pd = 16'h0015;
    @(posedge clk); #1;
    rst = 1'b0;
    dv[1] = 1'b0;
    check("rst_vs_valid_busy", {31'b0, busy_w[1]}, 32'h0);
    check("rst_vs_valid_tx", {31'b0, tx_w[1]}, 32'h1);
    repeat (3) begin
      @(posedge clk); #1;
    end

    // Randomised frames across all widths with churned inputs.
    for (int r = 0; r < 24; r++) begin
      send($urandom_range(0, 2), 16'($urandom), 1'($urandom), 1'($urandom),
           1'($urandom), 1'($urandom));
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Parametrised UART transmit frame engine: it accepts a parallel word on a valid strobe and serialises it onto TX_OUT as start bit, DATA_WIDTH data bits LSB-first, an optional parity bit, and one or two stop bits. It contains its own FSM, bit counter, parity generator and output selection, so it replaces a fixed 8-bit transmitter and its separate output mux in the UART_TX path. It runs one bit per CLK cycle, so CLK is the TX baud-rate clock from the clock divider.

## Interface
Parameters:
- DATA_WIDTH, default 8: data bits per frame; legal range 2..16.
- IDLE_LEVEL, default 1'b1: line level in IDLE and during stop bits; the start bit is ~IDLE_LEVEL.

Ports:
- CLK  input  1  baud-rate clock. One clock domain; reset is synchronous and active-high.
- RST  input  1  synchronous reset, active-high.
- P_DATA  input  DATA_WIDTH  parallel word to transmit.
- Data_Valid  input  1  request strobe; sampled on CLK rising edge.
- PAR_EN  input  1  1 = insert parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- STOP2  input  1  1 = two stop bits, 0 = one stop bit.
- TX_OUT  output  1  serial line; registered.
- Busy  output  1  high while a frame is on the line; registered.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - TX_OUT=IDLE_LEVEL and Busy=0.
  - If Data_Valid=1, the block latches P_DATA, PAR_EN, PAR_TYP and STOP2, computes the parity bit from the latched word, and moves to START.
- START: TX_OUT=~IDLE_LEVEL for 1 cycle, then DATA.
- DATA:
  - Transmits latched data bit[cnt] for cnt = 0..DATA_WIDTH-1, one bit per cycle.
  - cnt is a $clog2(DATA_WIDTH)-bit counter, cleared on entry to DATA.
  - After bit DATA_WIDTH-1, goes to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY:
  - Transmits ^data when PAR_TYP=0 and ~(^data) when PAR_TYP=1, for 1 cycle.
  - Parity is computed over the latched word only.
- STOP: TX_OUT=IDLE_LEVEL for 1 cycle, or 2 cycles if the latched STOP2=1; then IDLE.
- Busy=1 in START, DATA, PARITY and STOP.
- Data_Valid is ignored while Busy=1. No queueing and no error flag.
- Changes to P_DATA or any config input while Busy=1 have no effect on the current frame.
- An undefined or illegal state encoding recovers to IDLE with TX_OUT=IDLE_LEVEL.

## Timing
- Reset: on any CLK edge with RST=1, the next cycle has state=IDLE, TX_OUT=IDLE_LEVEL, Busy=0 and cnt=0. Latched data and config are don't-care.
- Reset mid-frame aborts the frame immediately; no partial stop bit is appended.
- Latency: if Data_Valid=1 is sampled at edge k (state IDLE), the start bit and Busy=1 both appear after edge k.
- Frame length (Busy high) is N = 1 + DATA_WIDTH + PAR_EN + (STOP2 ? 2 : 1) cycles.
- Busy falls on the same edge that TX_OUT leaves the final stop bit for IDLE.
- Back-to-back frames: Data_Valid held high gives a minimum of one IDLE cycle between the last stop bit and the next start bit. Frame period is N+1 cycles.
- Data_Valid and RST high on the same edge: reset wins and nothing is latched.
- DATA_WIDTH a power of two: the counter must not wrap early. Comparison is against DATA_WIDTH-1, not overflow.

## Test plan
- Basic frame, parity even: DATA_WIDTH=8, P_DATA=8'hA5, PAR_EN=1, PAR_TYP=0, STOP2=0, one Data_Valid pulse.
  - TX_OUT after accept: 0,1,0,1,0,0,1,0,1,0,1 (start, data LSB-first, parity 0, stop).
  - Busy high for exactly 11 cycles, then TX_OUT=1 and Busy=0.
- Odd parity, two stops, parity off:
  - P_DATA=8'h01, PAR_EN=1, PAR_TYP=1, STOP2=1: parity bit=0 and frame is 12 cycles.
  - Same word with PAR_EN=0: frame is 11 cycles with no parity slot.
- Width sweep:
  - DATA_WIDTH=5, P_DATA=5'h1F, PAR_EN=1, PAR_TYP=0, STOP2=0: bits 0,1,1,1,1,1,1,1 and frame is 8 cycles.
  - DATA_WIDTH=16 with P_DATA=16'h8001: MSB is sent in the 16th data slot.
- Input stability:
  - Change P_DATA, PAR_TYP and STOP2 every cycle while Busy=1: the frame matches the values latched at accept.
  - Data_Valid pulses during Busy are ignored: exactly one frame is sent.
- Back-to-back: Data_Valid held high with 8'h55 then 8'hAA: exactly one IDLE cycle (TX_OUT=1, Busy=0) between frames, and both frames are correct.
- Reset mid-frame: assert RST during the 4th data bit.
  - Next cycle TX_OUT=1 and Busy=0.
  - A new request afterwards produces a clean full frame.
